spi_ssel_arbiter: RTL and testbench
===================================

Name: spi_ssel_arbiter

Overview:
- Sits between the board SPI slave-select pins and the NUM_CH spi_to_neopix controllers, which share one MISO pin.
- Synchronises the raw active-low selects and grants exactly one channel per SPI frame.
- Forwards a gated select to the granted controller only, and steers that controller's MISO to the pad.
- Detects and counts host select conflicts: overlapping selects, or a select asserted while another channel holds the grant.

Parameters:
- NUM_CH, 2, number of controller channels (2..8).
- SYNC_STAGES, 2, flip-flop stages on each raw select input (≥2).
- GUARD_CYCLES, 4, idle clk cycles enforced after a frame ends before the next grant (≥1).
- CNT_W, 8, width of the saturating conflict counter.
- TIMEOUT_CYCLES, 50000000, maximum grant length in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock; all logic is in this single domain.
- reset_i  in  1  synchronous, active-high reset.
- ssel_i  in  NUM_CH  raw active-low selects from pins; asynchronous.
- miso_i  in  NUM_CH  MISO from each controller.
- ssel_o  out  NUM_CH  gated active-low selects to the controllers.
- miso_o  out  1  MISO to the pad.
- grant_o  out  NUM_CH  one-hot current grant; all-zero when idle.
- conflict_o  out  1  sticky conflict flag.
- conflict_clr_i  in  1  single-cycle pulse; clears conflict_o and conflict_cnt_o.
- conflict_cnt_o  out  CNT_W  saturating conflict count.

Behaviour:
- Reset: ssel_o all 1, grant_o 0, miso_o 1, conflict_o 0, conflict_cnt_o 0, state IDLE, every per-channel arm bit 0, synchroniser flops 1.
- Arming: a channel's arm bit sets when its synchronised select (ss) is seen high. Only armed channels can be granted. This means a select already low when reset releases is ignored until it goes high, so a controller never receives a partial frame.
- IDLE:
  - Exactly one armed ss low → GRANT that channel. grant_o and ssel_o update on the next clk edge. Latency from the raw select edge to ssel_o low is SYNC_STAGES+1 cycles.
  - Two or more armed ss low in the same cycle → CONFLICT. No grant is made. conflict_o is set and the counter increments once.
- GRANT:
  - ssel_o[g] follows ss[g].
  - All other ssel_o bits stay 1.
  - miso_o = miso_i[g].
  - Any other armed ss going low (falling edge of ss) sets conflict_o and increments the counter once per edge. That channel is disarmed until it goes high again.
  - When ss[g] goes high: ssel_o[g] goes to 1 and grant_o to 0 on the next edge, and the state moves to GUARD.
- GUARD: counts GUARD_CYCLES cycles with no grant, then returns to IDLE.
- CONFLICT: stays here until every ss is high, then moves to GUARD.
- If the granted select releases in the same cycle another select asserts: GUARD runs first. The other channel is granted afterwards if it is still low and armed.
- miso_o is 1 whenever no channel is granted.
- Counter: saturates at 2^CNT_W−1. If conflict_clr_i coincides with a new conflict, the clear wins and the new event is dropped.
- Host timing contract: ≥ SYNC_STAGES+2 clk cycles from select fall to the first SCK edge, and ≥ GUARD_CYCLES+SYNC_STAGES+1 cycles between frames.
- Reset asserted mid-frame: the reset values above apply on the next edge, and the active channel must go high before it can be granted again.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in GRANT.
  - When it reaches TIMEOUT_CYCLES, ssel_o[g] is forced to 1, the channel is disarmed, conflict_o is set, the counter increments, and the state moves to GUARD.
  - The channel must deassert before it can be granted again.
- Undefined: a grant lasts until its select deasserts; no timeout logic is synthesised.

Test Plan:
1. Reset 5 cycles, then ssel_i=2'b10 held for 100 cycles → ssel_o=2'b10 exactly 3 cycles after the edge, grant_o=2'b01, miso_o tracks miso_i[0], conflict_cnt_o=0.
2. ssel_i 2'b11→2'b00 in one cycle → no grant, ssel_o=2'b11, conflict_o=1, conflict_cnt_o=1. Then release to 2'b11, wait 4 guard cycles, drive 2'b01 → ch1 granted.
3. Channel 0 granted, then ssel_i[1] falls → ssel_o[1] stays 1, conflict_cnt_o=1. Release ch0 while ch1 is still low → no grant to ch1 until it goes high and low again.
4. ssel_i[0] low across reset release → never granted. Drive it high for 3 cycles, then low → granted after 3 cycles.
5. Pulse conflict_clr_i with conflict_cnt_o at 255 (CNT_W=8) → count 0 and conflict_o 0 next cycle. Force 300 conflicts → count saturates at 255.
6. SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20: hold ch0 low for 50 cycles → ssel_o[0]=1 at grant cycle 20, conflict_cnt_o=1, no re-grant while still low.

Source files
------------

// File: rtl/spi_ssel_arbiter.sv
// spi_ssel_arbiter: grants one of NUM_CH SPI controllers per host frame,
// gates its slave select, steers its MISO to the shared pad and counts
// host select conflicts.
// Optional build macro SPI_ARB_TIMEOUT_EN: bounds each grant to
// TIMEOUT_CYCLES clk cycles; without it a grant lasts until its select
// deasserts.
module spi_ssel_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int GUARD_CYCLES   = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] ssel_i,
  input  logic [NUM_CH-1:0] miso_i,
  output logic [NUM_CH-1:0] ssel_o,
  output logic              miso_o,
  output logic [NUM_CH-1:0] grant_o,
  output logic              conflict_o,
  input  logic              conflict_clr_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT    = 2'd1;
  localparam logic [1:0] ST_GUARD    = 2'd2;
  localparam logic [1:0] ST_CONFLICT = 2'd3;

  localparam int CHW = $clog2(NUM_CH + 1);
  localparam int GW  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  // Saturating add of a small event count onto the conflict counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CHW-1:0]   b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [CHW-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [CHW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + CHW'(v[i]);
    return n;
  endfunction

  logic [NUM_CH-1:0]      sync_p [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_p;
  logic [NUM_CH-1:0]      ss;
  logic [NUM_CH-1:0]      ss_prev;

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] arm_q, arm_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [CHW-1:0]    evt_inc;
  logic              cnt_sat;
  logic [NUM_CH-1:0] armed_low;
  logic [NUM_CH-1:0] fall;
  logic              one_low;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  assign ss        = sync_p[SYNC_STAGES-1];
  assign armed_low = arm_q & ~ss;
  assign one_low   = (armed_low != '0) && ((armed_low & (armed_low - CH_ONE)) == '0);
  assign fall      = ss_prev & ~ss & arm_q & ~grant_q;

  // Raw select synchroniser; vld_p marks when the chain holds real pin samples.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '1;
      vld_p   <= '0;
      ss_prev <= '1;
    end else begin
      sync_p[0] <= ssel_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      vld_p   <= {vld_p[SYNC_STAGES-2:0], 1'b1};
      ss_prev <= ss;
    end
  end

  // Arbitration FSM next-state, arming and conflict event detection.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    arm_d   = arm_q;
    gcnt_d  = gcnt_q;
    evt_inc = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    tmr_d   = tmr_q;
`endif
    // Arming waits for the synchroniser to flush its reset value, so a
    // select held low through reset is never mistaken for a fresh high.
    if (vld_p[SYNC_STAGES-1]) arm_d = arm_q | ss;
    case (state_q)
      ST_IDLE: begin
        gcnt_d = '0;
        if (one_low) begin
          grant_d = armed_low;
          state_d = ST_GRANT;
`ifdef SPI_ARB_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end else if (armed_low != '0) begin
          evt_inc = CHW'(1);
          state_d = ST_CONFLICT;
        end
      end
      ST_GRANT: begin
        if ((grant_q & ss) != '0) begin
          // Release wins over a simultaneous assert elsewhere: guard first.
          grant_d = '0;
          gcnt_d  = '0;
          state_d = ST_GUARD;
        end else begin
          evt_inc = popcnt(fall);
          arm_d   = arm_d & ~fall;
`ifdef SPI_ARB_TIMEOUT_EN
          if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            arm_d   = arm_d & ~grant_q;
            grant_d = '0;
            gcnt_d  = '0;
            evt_inc = evt_inc + CHW'(1);
            state_d = ST_GUARD;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
`endif
        end
      end
      ST_GUARD: begin
        if (gcnt_q == GW'(GUARD_CYCLES - 1)) state_d = ST_IDLE;
        else                                 gcnt_d  = gcnt_q + GW'(1);
      end
      ST_CONFLICT: begin
        if (&ss) begin
          gcnt_d  = '0;
          state_d = ST_GUARD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, grant, arm and guard-counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      arm_q   <= '0;
      gcnt_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      arm_q   <= arm_d;
      gcnt_q  <= gcnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  assign cnt_sat = 1'b0;

  // Sticky conflict flag and saturating counter; a clear drops coincident events.
  always_ff @(posedge clk_i) begin
    if (reset_i || conflict_clr_i) begin
      conflict_o     <= 1'b0;
      conflict_cnt_o <= '0;
    end else if (evt_inc != '0) begin
      conflict_o     <= 1'b1;
      conflict_cnt_o <= sat_add(conflict_cnt_o, evt_inc);
    end
  end

  assign grant_o = grant_q;
  assign ssel_o  = ~grant_q | {NUM_CH{cnt_sat}};
  assign miso_o  = (grant_q == '0) ? 1'b1 : |(grant_q & miso_i);

endmodule

// File: tb/tb_spi_ssel_arbiter.sv
// Directed bench for spi_ssel_arbiter (NUM_CH=2, CNT_W=8).
module tb_spi_ssel_arbiter;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int HOLD1 = 15;
`else
  localparam int HOLD1 = 100;
`endif

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NUM_CH-1:0] ssel_i;
  logic [NUM_CH-1:0] miso_i;
  logic [NUM_CH-1:0] ssel_o;
  logic              miso_o;
  logic [NUM_CH-1:0] grant_o;
  logic              conflict_o;
  logic              conflict_clr_i;
  logic [CNT_W-1:0]  conflict_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  spi_ssel_arbiter #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(2), .GUARD_CYCLES(4),
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ssel_i(ssel_i), .miso_i(miso_i),
    .ssel_o(ssel_o), .miso_o(miso_o), .grant_o(grant_o),
    .conflict_o(conflict_o), .conflict_clr_i(conflict_clr_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_conflict();
    ssel_i = 2'b00;
    tick(3);
    ssel_i = 2'b11;
    tick(9);
  endtask

  initial begin
    reset_i = 1'b1; ssel_i = 2'b11; miso_i = 2'b00; conflict_clr_i = 1'b0;
    tick(5);
    chk("rst_ssel",  ssel_o, 2'b11);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_miso",  miso_o, 1'b1);
    chk("rst_flag",  conflict_o, 1'b0);
    chk("rst_cnt",   conflict_cnt_o, 8'd0);
    reset_i = 1'b0;
    tick(5);

    // Single channel frame on ch0
    ssel_i = 2'b10;
    tick(2);
    chk("t1_ssel_early", ssel_o, 2'b11);
    tick(1);
    chk("t1_ssel",  ssel_o, 2'b10);
    chk("t1_grant", grant_o, 2'b01);
    miso_i = 2'b01; #1;
    chk("t1_miso_hi", miso_o, 1'b1);
    miso_i = 2'b10; #1;
    chk("t1_miso_lo", miso_o, 1'b0);
    tick(HOLD1);
    chk("t1_hold_grant", grant_o, 2'b01);
    chk("t1_hold_ssel",  ssel_o, 2'b10);
    chk("t1_cnt",        conflict_cnt_o, 8'd0);
    ssel_i = 2'b11;
    tick(2);
    chk("t1_rel_early", grant_o, 2'b01);
    tick(1);
    chk("t1_rel_grant", grant_o, 2'b00);
    chk("t1_rel_ssel",  ssel_o, 2'b11);
    chk("t1_idle_miso", miso_o, 1'b1);
    tick(8);

    // Simultaneous selects
    ssel_i = 2'b00;
    tick(3);
    chk("t2_grant", grant_o, 2'b00);
    chk("t2_ssel",  ssel_o, 2'b11);
    chk("t2_flag",  conflict_o, 1'b1);
    chk("t2_cnt",   conflict_cnt_o, 8'd1);
    tick(5);
    chk("t2_cnt_once", conflict_cnt_o, 8'd1);
    ssel_i = 2'b11;
    tick(10);
    ssel_i = 2'b01;
    tick(3);
    chk("t2_ch1_grant", grant_o, 2'b10);
    chk("t2_ch1_ssel",  ssel_o, 2'b01);
    miso_i = 2'b10; #1;
    chk("t2_miso_hi", miso_o, 1'b1);
    miso_i = 2'b01; #1;
    chk("t2_miso_lo", miso_o, 1'b0);
    ssel_i = 2'b11;
    tick(10);

    // Select asserted during another channel's grant
    conflict_clr_i = 1'b1;
    tick(1);
    conflict_clr_i = 1'b0;
    chk("t3_clr_cnt",  conflict_cnt_o, 8'd0);
    chk("t3_clr_flag", conflict_o, 1'b0);
    ssel_i = 2'b10;
    tick(3);
    chk("t3_grant0", grant_o, 2'b01);
    ssel_i = 2'b00;
    tick(3);
    chk("t3_cnt",   conflict_cnt_o, 8'd1);
    chk("t3_flag",  conflict_o, 1'b1);
    chk("t3_ssel",  ssel_o, 2'b10);
    chk("t3_grant", grant_o, 2'b01);
    tick(3);
    chk("t3_cnt_once", conflict_cnt_o, 8'd1);
    ssel_i = 2'b01;
    tick(15);
    chk("t3_no_grant1", grant_o, 2'b00);
    chk("t3_no_ssel1",  ssel_o, 2'b11);
    ssel_i = 2'b11;
    tick(5);
    ssel_i = 2'b01;
    tick(3);
    chk("t3_regrant1", grant_o, 2'b10);
    ssel_i = 2'b11;
    tick(10);

    // Reset mid-frame with the select held low across release
    ssel_i = 2'b10;
    tick(3);
    chk("t4_pre_grant", grant_o, 2'b01);
    reset_i = 1'b1;
    tick(1);
    chk("t4_rst_grant", grant_o, 2'b00);
    chk("t4_rst_ssel",  ssel_o, 2'b11);
    chk("t4_rst_cnt",   conflict_cnt_o, 8'd0);
    tick(4);
    reset_i = 1'b0;
    tick(20);
    chk("t4_held_grant", grant_o, 2'b00);
    chk("t4_held_ssel",  ssel_o, 2'b11);
    ssel_i = 2'b11;
    tick(3);
    ssel_i = 2'b10;
    tick(2);
    chk("t4_early", grant_o, 2'b00);
    tick(1);
    chk("t4_grant", grant_o, 2'b01);
    chk("t4_ssel",  ssel_o, 2'b10);
    ssel_i = 2'b11;
    tick(10);

    // Counter saturation and clear priority
    for (int i = 0; i < 255; i++) do_conflict();
    chk("t5_cnt255", conflict_cnt_o, 8'd255);
    chk("t5_flag",   conflict_o, 1'b1);
    conflict_clr_i = 1'b1;
    tick(1);
    conflict_clr_i = 1'b0;
    chk("t5_clr_cnt",  conflict_cnt_o, 8'd0);
    chk("t5_clr_flag", conflict_o, 1'b0);
    for (int i = 0; i < 300; i++) do_conflict();
    chk("t5_sat", conflict_cnt_o, 8'd255);
    conflict_clr_i = 1'b1;
    tick(1);
    conflict_clr_i = 1'b0;
    chk("t5_clr2_cnt", conflict_cnt_o, 8'd0);
    ssel_i = 2'b00;
    tick(2);
    conflict_clr_i = 1'b1;
    tick(1);
    conflict_clr_i = 1'b0;
    chk("t5_coinc_cnt",  conflict_cnt_o, 8'd0);
    chk("t5_coinc_flag", conflict_o, 1'b0);
    tick(3);
    chk("t5_coinc_after", conflict_cnt_o, 8'd0);
    ssel_i = 2'b11;
    tick(10);

`ifdef SPI_ARB_TIMEOUT_EN
    // Grant timeout after 20 cycles
    ssel_i = 2'b10;
    tick(3);
    chk("t6_grant", grant_o, 2'b01);
    tick(19);
    chk("t6_before", ssel_o, 2'b10);
    tick(1);
    chk("t6_ssel",  ssel_o, 2'b11);
    chk("t6_grant_off", grant_o, 2'b00);
    chk("t6_cnt",   conflict_cnt_o, 8'd1);
    chk("t6_flag",  conflict_o, 1'b1);
    tick(27);
    chk("t6_no_regrant", grant_o, 2'b00);
    ssel_i = 2'b11;
    tick(10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
